tron_input_ctrl: RTL and testbench
==================================

TRON_INPUT_CTRL -- requirements
Module: tron_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20'd500000; input stable count, in clocks, required to accept a button level.
REQ-002 Parameter COUNTDOWN_FRAMES, default 8'd180; frames spent in COUNTDOWN before play.
REQ-003 clock  input  1  system clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame_tick  input  1  one-clock pulse per frame end (row 599, col 799), the same instant positions update.
REQ-006 p1_btn, p2_btn  input  4 each  raw asynchronous buttons {right,left,down,up}, active-high.
REQ-007 start_btn  input  1  raw asynchronous start button, active-high.
REQ-008 p1_crash, p2_crash  input  1 each  synchronous collision flags from the collision stage.
REQ-009 p1_info, p2_info  output  4 each  one-hot direction: 0001 up, 0010 down, 0100 left, 1000 right, 0000 stop.
REQ-010 dflt  output  1  high forces both players to their start positions.
REQ-011 winner  output  2  00 none, 01 P1, 10 P2, 11 draw.
REQ-012 p1_score, p2_score  output  4 each  rounds won, saturating.

Function
REQ-013 Every raw button (9 total) shall pass a 2-flop synchronizer, then a debouncer that updates its clean level only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-014 A debounced start "press" shall be its 0->1 transition, one clock wide.
REQ-015 FSM states IDLE, COUNTDOWN, PLAY, OVER; reset enters IDLE.
REQ-016 IDLE: dflt=1, p_info=0000; start press -> COUNTDOWN.
REQ-017 COUNTDOWN: dflt=1, p_info=0000; frame counter cleared on entry and incremented per frame_tick; on the tick making it equal COUNTDOWN_FRAMES -> PLAY.
REQ-018 On COUNTDOWN entry, committed and pending directions shall load P1=UP (0001), P2=DOWN (0010), and winner shall clear to 00.
REQ-019 PLAY: dflt=0, p_info = committed direction of each player.
REQ-020 PLAY, per player: a debounced level with exactly one bit set, not equal to the opposite of the committed direction, shall load pending direction; zero or multiple bits set, or an opposite direction, shall leave pending unchanged.
REQ-021 Committed direction shall take the pending value only on frame_tick, so at most one turn per frame and no 180-degree reversal via two quick turns.
REQ-022 PLAY: on any cycle with p1_crash or p2_crash high -> OVER; winner = 10 if only p1_crash, 01 if only p2_crash, 11 if both in the same cycle.
REQ-023 Crash and frame_tick in the same cycle: crash wins; committed direction is not updated.
REQ-024 Entering OVER with winner 01 increments p1_score, 10 increments p2_score, 11 neither; scores saturate at 15.
REQ-025 OVER: dflt=0, p_info=0000, winner held; start press -> COUNTDOWN.
REQ-026 Crash inputs outside PLAY shall be ignored; start presses outside IDLE/OVER shall be ignored.
REQ-027 All outputs shall be registered; p_info changes one clock after the frame_tick that commits.

Reset
REQ-028 Reset shall set state IDLE, dflt=1, p1_info=p2_info=0000, winner=00, scores=0, frame counter 0, directions to the REQ-018 values, synchronizer and debouncer levels 0 and counters 0.
REQ-029 Reset asserted in any state, including mid-PLAY, shall take effect the next clock regardless of other inputs.

Structure
REQ-030 Shared package tron_pkg shall hold the state enum, the 4-bit direction constants (UP, DOWN, LEFT, RIGHT, STOP), the winner encodings and an opposite-direction function.
REQ-031 One sub-module, btn_debounce (synchronizer plus debouncer, one bit, parameter DEBOUNCE_CYCLES), instantiated 9 times.

Verification (DEBOUNCE_CYCLES=4, COUNTDOWN_FRAMES=3)
REQ-032 Reset, start held 10 clocks -> COUNTDOWN; after 3 frame_ticks dflt=0, p1_info=0001, p2_info=0010.
REQ-033 PLAY, P1 committed UP, press down -> at next tick p1_info stays 0001; press left -> 0100 after next tick.
REQ-034 P1 committed RIGHT, within one frame press UP then LEFT -> after tick p1_info=0100? No: pending=0001 then 0100 rejected against committed 1000 -> p1_info=0001.
REQ-035 Button glitch of 2 clocks -> no pending change; up+left together -> ignored.
REQ-036 p2_crash alone -> OVER, winner=01, p1_score=1, p_info=0000; p1_crash and p2_crash same cycle -> winner=11, scores unchanged.
REQ-037 p1_score=15, P1 wins again -> stays 15; reset mid-PLAY -> IDLE, dflt=1, scores 0.

Source files
------------

// File: rtl/tron_pkg.sv
// tron_pkg -- shared types and helpers for the Tron input controller.
//   state_t        : game FSM states
//   DIR_*          : one-hot direction codes {right,left,down,up}
//   WIN_*          : winner encodings
//   opposite()     : direction that would be a 180-degree reversal
//   is_onehot()    : exactly one bit set
//   sat_inc()      : 4-bit saturating increment
package tron_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COUNTDOWN,
      ST_PLAY,
      ST_OVER
   } state_t;

   localparam logic [3:0] DIR_STOP  = 4'b0000;
   localparam logic [3:0] DIR_UP    = 4'b0001;
   localparam logic [3:0] DIR_DOWN  = 4'b0010;
   localparam logic [3:0] DIR_LEFT  = 4'b0100;
   localparam logic [3:0] DIR_RIGHT = 4'b1000;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   function automatic logic [3:0] opposite(input logic [3:0] d);
      logic [3:0] r;
      case (d)
         DIR_UP:    r = DIR_DOWN;
         DIR_DOWN:  r = DIR_UP;
         DIR_LEFT:  r = DIR_RIGHT;
         DIR_RIGHT: r = DIR_LEFT;
         default:   r = DIR_STOP;
      endcase
      return r;
   endfunction

   function automatic logic is_onehot(input logic [3:0] d);
      return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? 4'hF : v + 4'd1;
   endfunction

endpackage

// File: rtl/tron_input_ctrl_btn_debounce.sv
// btn_debounce -- one-bit 2-flop synchronizer followed by a debouncer.
// The clean level follows the synchronized input only after
// DEBOUNCE_CYCLES consecutive samples that differ from the current level.
//   clock, reset : system clock, synchronous active-high reset
//   raw_i        : raw asynchronous button
//   level_o      : debounced, registered level
module btn_debounce #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_i,
   output logic level_o
);

   localparam logic [19:0] CNT_LAST = (DEBOUNCE_CYCLES == 20'd0) ? 20'd0
                                                                 : DEBOUNCE_CYCLES - 20'd1;

   logic        sync1_q, sync2_q;
   logic        level_q, level_d;
   logic [19:0] cnt_q, cnt_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q >= CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 20'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/tron_input_ctrl.sv
// tron_input_ctrl -- button conditioning and game-flow FSM for a two-player
// Tron game (IDLE -> COUNTDOWN -> PLAY -> OVER).
//   clock, reset           : system clock, synchronous active-high reset
//   frame_tick             : one-clock pulse per frame end
//   p1_btn, p2_btn [3:0]   : raw buttons {right,left,down,up}
//   start_btn              : raw start button
//   p1_crash, p2_crash     : collision flags, honoured only in PLAY
//   p1_info, p2_info [3:0] : registered one-hot direction (0 = stop)
//   dflt                   : forces both players to start positions
//   winner [1:0]           : 00 none, 01 P1, 10 P2, 11 draw
//   p1_score, p2_score     : saturating round-win counters
module tron_input_ctrl #(
   parameter logic [19:0] DEBOUNCE_CYCLES  = 20'd500000,
   parameter logic [7:0]  COUNTDOWN_FRAMES = 8'd180
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic [3:0] p1_btn,
   input  logic [3:0] p2_btn,
   input  logic       start_btn,
   input  logic       p1_crash,
   input  logic       p2_crash,
   output logic [3:0] p1_info,
   output logic [3:0] p2_info,
   output logic       dflt,
   output logic [1:0] winner,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score
);

   import tron_pkg::*;

   // ---------------- button conditioning ----------------
   logic [8:0] raw_all;
   logic [8:0] lvl_all;

   assign raw_all = {start_btn, p2_btn, p1_btn};

   for (genvar g = 0; g < 9; g++) begin : g_deb
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clock  (clock),
         .reset  (reset),
         .raw_i  (raw_all[g]),
         .level_o(lvl_all[g])
      );
   end

   logic [3:0] p1_lvl, p2_lvl;
   logic       start_lvl, start_prev_q, start_press;

   assign p1_lvl      = lvl_all[3:0];
   assign p2_lvl      = lvl_all[7:4];
   assign start_lvl   = lvl_all[8];
   assign start_press = start_lvl & ~start_prev_q;

   // ---------------- game FSM ----------------
   state_t     state_q;
   logic [7:0] frame_cnt_q;
   logic [3:0] p1_cmt_q, p1_pend_q, p2_cmt_q, p2_pend_q;
   logic [3:0] p1_info_q, p2_info_q;
   logic       dflt_q;
   logic [1:0] winner_q;
   logic [3:0] p1_score_q, p2_score_q;

   // A new pending turn is validated against the direction that will be
   // committed after this cycle, so a tick coinciding with a press can never
   // queue a reversal of the freshly committed direction.
   logic [3:0] p1_cmt_nxt, p2_cmt_nxt;
   logic       p1_turn_ok, p2_turn_ok;

   assign p1_cmt_nxt = frame_tick ? p1_pend_q : p1_cmt_q;
   assign p2_cmt_nxt = frame_tick ? p2_pend_q : p2_cmt_q;
   assign p1_turn_ok = is_onehot(p1_lvl) && (p1_lvl != opposite(p1_cmt_nxt));
   assign p2_turn_ok = is_onehot(p2_lvl) && (p2_lvl != opposite(p2_cmt_nxt));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         frame_cnt_q  <= '0;
         p1_cmt_q     <= DIR_UP;
         p1_pend_q    <= DIR_UP;
         p2_cmt_q     <= DIR_DOWN;
         p2_pend_q    <= DIR_DOWN;
         p1_info_q    <= DIR_STOP;
         p2_info_q    <= DIR_STOP;
         dflt_q       <= 1'b1;
         winner_q     <= WIN_NONE;
         p1_score_q   <= '0;
         p2_score_q   <= '0;
         start_prev_q <= 1'b0;
      end else begin
         start_prev_q <= start_lvl;
         unique case (state_q)
            ST_IDLE, ST_OVER: begin
               if (start_press) begin
                  state_q     <= ST_COUNTDOWN;
                  frame_cnt_q <= '0;
                  p1_cmt_q    <= DIR_UP;
                  p1_pend_q   <= DIR_UP;
                  p2_cmt_q    <= DIR_DOWN;
                  p2_pend_q   <= DIR_DOWN;
                  winner_q    <= WIN_NONE;
                  dflt_q      <= 1'b1;
                  p1_info_q   <= DIR_STOP;
                  p2_info_q   <= DIR_STOP;
               end
            end
            ST_COUNTDOWN: begin
               if (frame_tick) begin
                  frame_cnt_q <= frame_cnt_q + 8'd1;
                  if (frame_cnt_q + 8'd1 == COUNTDOWN_FRAMES) begin
                     state_q   <= ST_PLAY;
                     dflt_q    <= 1'b0;
                     p1_info_q <= p1_cmt_q;
                     p2_info_q <= p2_cmt_q;
                  end
               end
            end
            ST_PLAY: begin
               if (p1_crash || p2_crash) begin
                  // Crash beats a coincident frame_tick: nothing commits.
                  // {p1_crash,p2_crash} is exactly the winner encoding.
                  state_q   <= ST_OVER;
                  winner_q  <= {p1_crash, p2_crash};
                  p1_info_q <= DIR_STOP;
                  p2_info_q <= DIR_STOP;
                  if (!p1_crash) p1_score_q <= sat_inc(p1_score_q);
                  if (!p2_crash) p2_score_q <= sat_inc(p2_score_q);
               end else begin
                  if (frame_tick) begin
                     p1_cmt_q  <= p1_pend_q;
                     p2_cmt_q  <= p2_pend_q;
                     p1_info_q <= p1_pend_q;
                     p2_info_q <= p2_pend_q;
                  end
                  if (p1_turn_ok) p1_pend_q <= p1_lvl;
                  if (p2_turn_ok) p2_pend_q <= p2_lvl;
               end
            end
         endcase
      end
   end

   assign p1_info  = p1_info_q;
   assign p2_info  = p2_info_q;
   assign dflt     = dflt_q;
   assign winner   = winner_q;
   assign p1_score = p1_score_q;
   assign p2_score = p2_score_q;

endmodule

// File: tb/tb_tron_input_ctrl.sv
// tb_tron_input_ctrl -- self-checking bench for tron_input_ctrl with
// DEBOUNCE_CYCLES=4 and COUNTDOWN_FRAMES=3. Expected outputs are queued as
// stimulus is applied and popped when the outputs are sampled.
module tb_tron_input_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic [3:0] p1_btn, p2_btn;
   logic       start_btn;
   logic       p1_crash, p2_crash;
   logic [3:0] p1_info, p2_info;
   logic       dflt;
   logic [1:0] winner;
   logic [3:0] p1_score, p2_score;

   tron_input_ctrl #(
      .DEBOUNCE_CYCLES (20'd4),
      .COUNTDOWN_FRAMES(8'd3)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .frame_tick(frame_tick),
      .p1_btn    (p1_btn),
      .p2_btn    (p2_btn),
      .start_btn (start_btn),
      .p1_crash  (p1_crash),
      .p2_crash  (p2_crash),
      .p1_info   (p1_info),
      .p2_info   (p2_info),
      .dflt      (dflt),
      .winner    (winner),
      .p1_score  (p1_score),
      .p2_score  (p2_score)
   );

   always #5 clock = ~clock;

   typedef struct {
      string      name;
      logic       dflt;
      logic [3:0] p1;
      logic [3:0] p2;
      logic [1:0] win;
      logic [3:0] s1;
      logic [3:0] s2;
   } exp_t;

   typedef struct {
      string      name;
      logic [3:0] p1b;
      logic [3:0] p2b;
      logic [3:0] p1e;
      logic [3:0] p2e;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[6];
   int   n_cmp = 0;
   int   n_err = 0;
   logic [3:0] s1 = 4'd0, s2 = 4'd0;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic hold(input int n);
      repeat (n) step();
   endtask

   task automatic push_exp(input string n, input logic d, input logic [3:0] a,
                           input logic [3:0] b, input logic [1:0] w,
                           input logic [3:0] x, input logic [3:0] y);
      exp_t e;
      e.name = n; e.dflt = d; e.p1 = a; e.p2 = b; e.win = w; e.s1 = x; e.s2 = y;
      exp_q.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL scoreboard_empty: no expectation queued");
      end else begin
         e = exp_q.pop_front();
         if ({dflt, p1_info, p2_info, winner, p1_score, p2_score} !==
             {e.dflt, e.p1, e.p2, e.win, e.s1, e.s2}) begin
            n_err++;
            $display("FAIL %s: got dflt=%b p1=%b p2=%b win=%b s1=%0d s2=%0d, want dflt=%b p1=%b p2=%b win=%b s1=%0d s2=%0d",
                     e.name, dflt, p1_info, p2_info, winner, p1_score, p2_score,
                     e.dflt, e.p1, e.p2, e.win, e.s1, e.s2);
         end
      end
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      hold(2);
   endtask

   task automatic press_start();
      start_btn = 1'b1;
      hold(10);
      start_btn = 1'b0;
      hold(10);
   endtask

   task automatic go_play();
      press_start();
      repeat (3) tick();
   endtask

   // Hold a button pattern long enough to debounce, release, then commit.
   task automatic apply_buttons(input logic [3:0] a, input logic [3:0] b);
      p1_btn = a;
      p2_btn = b;
      hold(8);
      p1_btn = 4'b0000;
      p2_btn = 4'b0000;
      hold(8);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{"rev_rejected",   4'b0010, 4'b0000, 4'b0001, 4'b0010};
      vecs[1] = '{"both_left",      4'b0100, 4'b0100, 4'b0100, 4'b0100};
      vecs[2] = '{"multi_bit",      4'b0101, 4'b0000, 4'b0100, 4'b0100};
      vecs[3] = '{"p1_rev_p2_up",   4'b1000, 4'b0001, 4'b0100, 4'b0001};
      vecs[4] = '{"p1_down_p2_rev", 4'b0010, 4'b0010, 4'b0010, 4'b0001};
      vecs[5] = '{"both_right",     4'b1000, 4'b1000, 4'b1000, 4'b1000};

      reset = 1'b1; frame_tick = 1'b0; p1_btn = '0; p2_btn = '0;
      start_btn = 1'b0; p1_crash = 1'b0; p2_crash = 1'b0;
      hold(3);
      reset = 1'b0;
      push_exp("reset", 1'b1, 4'b0000, 4'b0000, 2'b00, s1, s2);
      step();
      check_out();

      // Start -> COUNTDOWN; a start press mid-countdown must not restart it.
      push_exp("countdown", 1'b1, 4'b0000, 4'b0000, 2'b00, s1, s2);
      press_start();
      check_out();
      tick();
      press_start();
      tick();
      push_exp("cd_two_ticks", 1'b1, 4'b0000, 4'b0000, 2'b00, s1, s2);
      check_out();
      push_exp("play_entry", 1'b0, 4'b0001, 4'b0010, 2'b00, s1, s2);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check_out();

      // Two-clock glitch on P1 LEFT must not reach pending.
      p1_btn = 4'b0100;
      hold(2);
      p1_btn = 4'b0000;
      hold(10);
      push_exp("glitch", 1'b0, 4'b0001, 4'b0010, 2'b00, s1, s2);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check_out();

      for (int i = 0; i < 6; i++) begin
         push_exp(vecs[i].name, 1'b0, vecs[i].p1e, vecs[i].p2e, 2'b00, s1, s2);
         apply_buttons(vecs[i].p1b, vecs[i].p2b);
         check_out();
      end

      // P1 committed RIGHT: UP then LEFT in one frame -> LEFT rejected.
      p1_btn = 4'b0001;
      hold(8);
      p1_btn = 4'b0100;
      hold(8);
      p1_btn = 4'b0000;
      hold(8);
      push_exp("two_turns", 1'b0, 4'b0001, 4'b1000, 2'b00, s1, s2);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check_out();

      push_exp("start_in_play", 1'b0, 4'b0001, 4'b1000, 2'b00, s1, s2);
      press_start();
      check_out();

      s1 = 4'd1;
      push_exp("p2_crash", 1'b0, 4'b0000, 4'b0000, 2'b01, s1, s2);
      p2_crash = 1'b1;
      step();
      p2_crash = 1'b0;
      check_out();

      push_exp("crash_in_over", 1'b0, 4'b0000, 4'b0000, 2'b01, s1, s2);
      p1_crash = 1'b1;
      step();
      p1_crash = 1'b0;
      step();
      check_out();

      push_exp("restart", 1'b1, 4'b0000, 4'b0000, 2'b00, s1, s2);
      press_start();
      check_out();
      repeat (3) tick();
      push_exp("draw", 1'b0, 4'b0000, 4'b0000, 2'b11, s1, s2);
      p1_crash = 1'b1;
      p2_crash = 1'b1;
      step();
      p1_crash = 1'b0;
      p2_crash = 1'b0;
      check_out();

      go_play();
      s2 = 4'd1;
      push_exp("p1_crash", 1'b0, 4'b0000, 4'b0000, 2'b10, s1, s2);
      p1_crash = 1'b1;
      step();
      p1_crash = 1'b0;
      check_out();

      // Fifteen P1 wins from 1: the last one exercises saturation at 15.
      for (int r = 0; r < 15; r++) begin
         go_play();
         s1 = (s1 == 4'd15) ? 4'd15 : s1 + 4'd1;
         push_exp("sat_round", 1'b0, 4'b0000, 4'b0000, 2'b01, s1, s2);
         p2_crash = 1'b1;
         step();
         p2_crash = 1'b0;
         check_out();
      end

      go_play();
      s1 = 4'd0;
      s2 = 4'd0;
      push_exp("reset_mid_play", 1'b1, 4'b0000, 4'b0000, 2'b00, s1, s2);
      reset = 1'b1;
      p1_crash = 1'b1;
      frame_tick = 1'b1;
      step();
      reset = 1'b0;
      p1_crash = 1'b0;
      frame_tick = 1'b0;
      check_out();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
